// File: rtl/mem_request_unit.sv
// mem_request_unit: sequences imem/dmem requests, PC advance and RF write
// in: CLK RST ihit dhit cu_dREN/dWEN/RegWr/halt; out: imemREN dmemREN dmemWEN pc_en rf_wen halt_out err stall_cnt
module mem_request_unit #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int STALL_W        = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ihit,
  input  logic               dhit,
  input  logic               cu_dREN,
  input  logic               cu_dWEN,
  input  logic               cu_RegWr,
  input  logic               cu_halt,
  output logic               imemREN,
  output logic               dmemREN,
  output logic               dmemWEN,
  output logic               pc_en,
  output logic               rf_wen,
  output logic               halt_out,
  output logic               err,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    HALTED
  } state_e;

  state_e state_q, state_d;

  logic dren_q, dren_d;
  logic dwen_q, dwen_d;
  logic regwr_q, regwr_d;
  logic halt_q, halt_d;
  logic err_q, err_d;

  logic [TW-1:0]      tmo_q, tmo_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic mem_op;

  assign mem_op = cu_dREN | cu_dWEN;

  always_comb begin
    state_d = state_q;
    dren_d  = dren_q;
    dwen_d  = dwen_q;
    regwr_d = regwr_q;
    halt_d  = halt_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    stall_d = stall_q;
    pc_en   = 1'b0;
    rf_wen  = 1'b0;

    case (state_q)
      RUN: begin
        if (ihit) begin
          if (cu_halt) begin
            state_d = HALTED;
            halt_d  = 1'b1;
          end else if (mem_op) begin
            dren_d  = cu_dREN;
            dwen_d  = cu_dWEN;
            regwr_d = cu_RegWr;
            tmo_d   = '0;
            state_d = DWAIT;
          end else begin
            pc_en  = 1'b1;
            rf_wen = cu_RegWr;
          end
        end
      end
      DWAIT: begin
        if (dhit) begin
          pc_en   = 1'b1;
          // stores complete without a register write
          rf_wen  = regwr_q & dren_q;
          dren_d  = 1'b0;
          dwen_d  = 1'b0;
          tmo_d   = '0;
          state_d = RUN;
        end else if (TIMEOUT_CYCLES > 0) begin
          // this is the last allowed DWAIT cycle
          if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            halt_d  = 1'b1;
            dren_d  = 1'b0;
            dwen_d  = 1'b0;
            tmo_d   = '0;
            state_d = HALTED;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      HALTED: begin
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (state_q != HALTED && !pc_en &&
        stall_q != {STALL_W{1'b1}}) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      regwr_q <= 1'b0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      dren_q  <= dren_d;
      dwen_q  <= dwen_d;
      regwr_q <= regwr_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      stall_q <= stall_d;
    end
  end

  assign imemREN   = (state_q == RUN);
  assign dmemREN   = dren_q;
  assign dmemWEN   = dwen_q;
  assign halt_out  = halt_q;
  assign err       = err_q;
  assign stall_cnt = stall_q;

  a_rw_excl: assert property (
    @(posedge CLK) disable iff (RST)
    !(dmemREN && dmemWEN));

  a_pc_ihit: assert property (
    @(posedge CLK) disable iff (RST)
    pc_en |=> (!pc_en || ihit));

endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: random + directed stimulus, queue scoreboard
// against a behavioural model of the request sequencer
module tb_mem_request_unit;

  localparam int TMO  = 8;
  localparam int SW_  = 5;
  localparam int SMAX = 31;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit = 1'b0, dhit = 1'b0;
  logic cu_dREN = 1'b0, cu_dWEN = 1'b0;
  logic cu_RegWr = 1'b0, cu_halt = 1'b0;
  logic imemREN, dmemREN, dmemWEN;
  logic pc_en, rf_wen, halt_out, err;
  logic [SW_-1:0] stall_cnt;

  mem_request_unit #(
    .TIMEOUT_CYCLES(TMO),
    .STALL_W(SW_)
  ) u_dut (
    .CLK(CLK), .RST(RST),
    .ihit(ihit), .dhit(dhit),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN),
    .cu_RegWr(cu_RegWr), .cu_halt(cu_halt),
    .imemREN(imemREN), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .pc_en(pc_en),
    .rf_wen(rf_wen), .halt_out(halt_out),
    .err(err), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic imem, dren, dwen, pc, rf, hlt, er;
    logic [SW_-1:0] st;
  } obs_t;

  obs_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  bit m_halt, m_err, m_wait, m_ld, m_st, m_rw;
  int m_wcnt, m_stall;

  task automatic model_reset();
    m_halt = 0; m_err = 0; m_wait = 0;
    m_ld = 0; m_st = 0; m_rw = 0;
    m_wcnt = 0; m_stall = 0;
  endtask

  task automatic chk(input string nm,
                     input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d",
               nm, $time, got, want);
    end
  endtask

  task automatic apply(input bit i, d, rd, wr, rw, h);
    obs_t e;
    bit pc, rf;
    ihit = i; dhit = d;
    cu_dREN = rd; cu_dWEN = wr;
    cu_RegWr = rw; cu_halt = h;
    if (m_halt) begin
      pc = 0; rf = 0;
    end else if (m_wait) begin
      pc = d; rf = d && m_rw && m_ld;
    end else begin
      pc = i && !h && !(rd || wr);
      rf = pc && rw;
    end
    e.imem = !m_halt && !m_wait;
    e.dren = m_wait && m_ld;
    e.dwen = m_wait && m_st;
    e.pc   = pc;
    e.rf   = rf;
    e.hlt  = m_halt;
    e.er   = m_err;
    e.st   = SW_'(m_stall);
    exp_q.push_back(e);
    if (!m_halt && !pc && m_stall < SMAX) m_stall++;
    if (m_halt) begin
    end else if (m_wait) begin
      if (d) begin
        m_wait = 0; m_wcnt = 0;
      end else begin
        m_wcnt++;
        if (m_wcnt == TMO) begin
          m_wait = 0; m_halt = 1; m_err = 1;
        end
      end
    end else if (i) begin
      if (h) m_halt = 1;
      else if (rd || wr) begin
        m_wait = 1; m_wcnt = 0;
        m_ld = rd; m_st = wr; m_rw = rw;
      end
    end
  endtask

  task automatic cycle(input bit i, d, rd, wr, rw, h);
    @(posedge CLK);
    #1;
    apply(i, d, rd, wr, rw, h);
  endtask

  task automatic idle(input int n, input bit d);
    for (int k = 0; k < n; k++)
      cycle(1'($urandom), d, 1'($urandom), 1'b0,
            1'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    ihit = 0; dhit = 0; cu_dREN = 0;
    cu_dWEN = 0; cu_RegWr = 0; cu_halt = 0;
    #2;
    chk("pre_rst_dren", int'(dmemREN),
        int'(m_wait && m_ld));
    RST = 1'b1;
    #1;
    chk("rst_dren", int'(dmemREN), 0);
    chk("rst_dwen", int'(dmemWEN), 0);
    chk("rst_imem", int'(imemREN), 1);
    chk("rst_halt", int'(halt_out), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_stall", int'(stall_cnt), 0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    model_reset();
    apply(0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {imemREN, dmemREN, dmemWEN, pc_en,
             rf_wen, halt_out, err, stall_cnt};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outs t=%0t got i%b r%b w%b p%b f%b h%b e%b s%0d want i%b r%b w%b p%b f%b h%b e%b s%0d",
            $time, a.imem, a.dren, a.dwen, a.pc, a.rf,
            a.hlt, a.er, a.st, e.imem, e.dren, e.dwen,
            e.pc, e.rf, e.hlt, e.er, e.st);
        end
      end
    end
  end

  initial begin : stim
    int dprob;
    bit i, d, rd, wr, h;
    model_reset();
    #3;
    chk("init_imem", int'(imemREN), 1);
    chk("init_dren", int'(dmemREN), 0);
    chk("init_stall", int'(stall_cnt), 0);
    do_reset();

    repeat (3) cycle(1, 0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 1, 0);

    cycle(1, 0, 1, 0, 1, 0);
    idle(3, 0);
    cycle(0, 1, 0, 0, 0, 0);

    cycle(1, 0, 0, 1, 0, 0);
    idle(1, 0);
    cycle(1, 1, 0, 0, 1, 0);

    cycle(1, 0, 1, 0, 1, 1);
    repeat (4) cycle(1, 1, 1, 0, 1, 0);
    do_reset();

    cycle(1, 0, 1, 0, 1, 0);
    idle(10, 0);
    do_reset();
    cycle(1, 0, 1, 0, 1, 0);
    idle(7, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);

    cycle(1, 0, 1, 0, 1, 0);
    idle(2, 0);
    do_reset();
    cycle(1, 0, 0, 0, 1, 0);

    dprob = 40;
    for (int n = 0; n < 1500; n++) begin
      if (n % 200 == 0) dprob = (dprob == 40) ? 6 : 40;
      if (m_halt || $urandom_range(99) == 0) begin
        do_reset();
      end else begin
        i  = $urandom_range(99) < 70;
        d  = $urandom_range(99) < dprob;
        h  = $urandom_range(59) == 0;
        rd = 0; wr = 0;
        case ($urandom_range(7))
          0, 1, 2: rd = 1;
          3, 4:    wr = 1;
          default: ;
        endcase
        cycle(i, d, rd, wr, 1'($urandom), h);
      end
    end

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
